// File: rtl/hls_run_sequencer.sv
// Batch run sequencer for an HLS accelerator: settles, starts and times each run, then reports it.
// Optional watchdog compiled in with `define HLS_RUN_SEQUENCER_TIMEOUT_EN.
module hls_run_sequencer #(
    parameter int CNT_W          = 32,
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 200000000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             go,
    input  logic [7:0]       num_runs,
    input  logic             abort,
    output logic             acc_reset_n,
    output logic             acc_start_port,
    input  logic             acc_done_port,
    output logic             busy,
    output logic             res_valid,
    output logic [CNT_W-1:0] res_cycles,
    output logic             res_timeout,
    output logic [7:0]       res_index,
    output logic             batch_done,
    output logic             batch_aborted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_ARM,
        S_START,
        S_WAIT,
        S_REPORT,
        S_DONE
    } state_t;

    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_ONE  = SETTLE_W'(1);
    localparam logic [CNT_W-1:0]    CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0]    CNT_MAX     = '1;

    state_t              r_state;
    state_t              w_next_state;
    logic [SETTLE_W-1:0] r_settle;
    logic [CNT_W-1:0]    r_cnt;
    logic [7:0]          r_last_idx;
    logic [7:0]          r_run_idx;
    logic [CNT_W-1:0]    r_res_cycles;
    logic                r_res_timeout;
    logic [7:0]          r_res_index;
    logic                r_batch_aborted;

    logic                w_go_accept;
    logic                w_capture;
    logic                w_set_aborted;
    logic                w_timeout;

`ifdef HLS_RUN_SEQUENCER_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
    // A done arriving in the same cycle as the limit still counts as a normal completion.
    assign w_timeout = (r_state == S_WAIT) && (r_cnt == TIMEOUT_VAL) && !acc_done_port;
`else
    assign w_timeout = 1'b0;
`endif

    assign w_go_accept = (r_state == S_IDLE) && go;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state  = r_state;
        w_capture     = 1'b0;
        w_set_aborted = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (go) begin
                    w_next_state = S_RST;
                end
            end
            S_RST: begin
                if (abort) begin
                    w_next_state  = S_DONE;
                    w_set_aborted = 1'b1;
                end else if (r_settle == SETTLE_LAST) begin
                    w_next_state = S_ARM;
                end
            end
            S_ARM: begin
                if (abort) begin
                    w_next_state  = S_DONE;
                    w_set_aborted = 1'b1;
                end else begin
                    w_next_state = S_START;
                end
            end
            S_START, S_WAIT: begin
                if (abort) begin
                    w_next_state  = S_DONE;
                    w_set_aborted = 1'b1;
                end else if (acc_done_port || w_timeout) begin
                    w_next_state = S_REPORT;
                    w_capture    = 1'b1;
                end else begin
                    w_next_state = S_WAIT;
                end
            end
            S_REPORT: begin
                if (abort || r_res_timeout) begin
                    w_next_state  = S_DONE;
                    w_set_aborted = 1'b1;
                end else if (r_run_idx == r_last_idx) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_RST;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_settle        <= '0;
            r_cnt           <= '0;
            r_last_idx      <= '0;
            r_run_idx       <= '0;
            r_res_cycles    <= '0;
            r_res_timeout   <= 1'b0;
            r_res_index     <= '0;
            r_batch_aborted <= 1'b0;
        end else begin
            r_settle <= (r_state == S_RST) ? r_settle + SETTLE_ONE : '0;

            // Loading in ARM makes the counter read 1 during the START cycle itself.
            if (r_state == S_ARM) begin
                r_cnt <= CNT_ONE;
            end else if (((r_state == S_START) || (r_state == S_WAIT)) && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + CNT_ONE;
            end

            if (w_go_accept) begin
                r_last_idx      <= (num_runs == 8'd0) ? 8'd0 : num_runs - 8'd1;
                r_run_idx       <= 8'd0;
                r_batch_aborted <= 1'b0;
            end else if ((r_state == S_REPORT) && (w_next_state == S_RST)) begin
                r_run_idx <= r_run_idx + 8'd1;
            end

            if (w_capture) begin
                r_res_cycles  <= r_cnt;
                r_res_timeout <= w_timeout;
                r_res_index   <= r_run_idx;
            end

            if (w_set_aborted) begin
                r_batch_aborted <= 1'b1;
            end
        end
    end

    assign acc_reset_n    = (r_state == S_ARM) || (r_state == S_START) ||
                            (r_state == S_WAIT) || (r_state == S_REPORT);
    assign acc_start_port = (r_state == S_START);
    assign busy           = (r_state != S_IDLE);
    assign res_valid      = (r_state == S_REPORT);
    assign batch_done     = (r_state == S_DONE);
    assign res_cycles     = r_res_cycles;
    assign res_timeout    = r_res_timeout;
    assign res_index      = r_res_index;
    assign batch_aborted  = r_batch_aborted;

endmodule

// File: tb/tb_hls_run_sequencer.sv
// Directed bench for hls_run_sequencer: a cycle monitor records starts/results, the driver plays the accelerator.
// Build with +define+HLS_RUN_SEQUENCER_TIMEOUT_EN to exercise the watchdog (limit 50).
module tb_hls_run_sequencer;

    localparam int SETTLE = 2;
`ifdef HLS_RUN_SEQUENCER_TIMEOUT_EN
    localparam int TMO = 50;
`else
    localparam int TMO = 1000;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        go = 1'b0;
    logic [7:0]  num_runs = 8'd0;
    logic        abort = 1'b0;
    logic        acc_done_port = 1'b0;
    logic        acc_reset_n;
    logic        acc_start_port;
    logic        busy;
    logic        res_valid;
    logic [31:0] res_cycles;
    logic        res_timeout;
    logic [7:0]  res_index;
    logic        batch_done;
    logic        batch_aborted;

    hls_run_sequencer #(
        .CNT_W         (32),
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .go            (go),
        .num_runs      (num_runs),
        .abort         (abort),
        .acc_reset_n   (acc_reset_n),
        .acc_start_port(acc_start_port),
        .acc_done_port (acc_done_port),
        .busy          (busy),
        .res_valid     (res_valid),
        .res_cycles    (res_cycles),
        .res_timeout   (res_timeout),
        .res_index     (res_index),
        .batch_done    (batch_done),
        .batch_aborted (batch_aborted)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Monitor state, sampled on the falling edge.
    int     cyc = 0;
    int     n_starts = 0, n_res = 0, n_done = 0;
    int     low_len = 0, last_low = 0, prev_start_cyc = 0;
    longint last_res = 0;
    logic   last_aborted = 1'b0;
    logic   prev_rstn = 1'b0, prev_start = 1'b0;
    bit     first_start = 1'b1;
    longint res_cyc_q[$];
    int     res_idx_q[$];
    int     res_to_q[$];

    function automatic longint qc(input int i);
        return (i < res_cyc_q.size()) ? res_cyc_q[i] : -1;
    endfunction
    function automatic int qi(input int i);
        return (i < res_idx_q.size()) ? res_idx_q[i] : -1;
    endfunction
    function automatic int qt(input int i);
        return (i < res_to_q.size()) ? res_to_q[i] : -1;
    endfunction

    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            low_len     = 0;
            first_start = 1'b1;
            prev_rstn   = 1'b0;
            prev_start  = 1'b0;
        end else begin
            if (!busy) first_start = 1'b1;
            if (acc_start_port) begin
                n_starts++;
                check("arm_cycle_before_start", {prev_rstn, prev_start}, 2);
                if (!first_start) begin
                    check("settle_low_cycles", last_low, SETTLE);
                    check("start_to_start", cyc - prev_start_cyc + 1, last_res + SETTLE + 3);
                end
                first_start    = 1'b0;
                prev_start_cyc = cyc;
            end
            if (res_valid) begin
                n_res++;
                res_cyc_q.push_back(res_cycles);
                res_idx_q.push_back(res_index);
                res_to_q.push_back(res_timeout);
                last_res = res_cycles;
            end
            if (batch_done) begin
                n_done++;
                last_aborted = batch_aborted;
            end
            if (!acc_reset_n) low_len++;
            else begin
                if (low_len != 0) last_low = low_len;
                low_len = 0;
            end
            prev_rstn  = acc_reset_n;
            prev_start = acc_start_port;
        end
    end

    task automatic clr();
        n_starts = 0; n_res = 0; n_done = 0;
        res_cyc_q.delete(); res_idx_q.delete(); res_to_q.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic start_batch(input int n, input logic with_abort);
        @(negedge clock);
        go = 1'b1; num_runs = 8'(n); abort = with_abort;
        @(negedge clock);
        go = 1'b0; abort = 1'b0;
    endtask

    task automatic wait_start(output bit seen);
        int k = 0;
        while (!acc_start_port && k < 200) begin @(negedge clock); k++; end
        seen = acc_start_port;
        if (!seen) check("start_seen", 0, 1);
    endtask

    // Accelerator model: done pulses lat cycles after the start pulse (0 = in the start cycle).
    task automatic serve(input int lat);
        bit seen;
        wait_start(seen);
        if (seen) begin
            repeat (lat) @(negedge clock);
            acc_done_port = 1'b1;
            @(negedge clock);
            acc_done_port = 1'b0;
        end
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!batch_done && k < budget) begin @(negedge clock); k++; end
        if (!batch_done) check("batch_done_seen", 0, 1);
        go = 1'b0;
        @(negedge clock);
    endtask

    task automatic check_all_zero(input string p);
        check({p, "_acc_reset_n"}, acc_reset_n, 0);
        check({p, "_acc_start"}, acc_start_port, 0);
        check({p, "_busy"}, busy, 0);
        check({p, "_res_valid"}, res_valid, 0);
        check({p, "_res_cycles"}, res_cycles, 0);
        check({p, "_res_timeout"}, res_timeout, 0);
        check({p, "_res_index"}, res_index, 0);
        check({p, "_batch_done"}, batch_done, 0);
        check({p, "_batch_aborted"}, batch_aborted, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        bit seen;
        tick(3);
        check_all_zero("reset");
        reset = 1'b0;
        tick(2);
        check("idle_acc_reset_n", acc_reset_n, 0);
        check("idle_busy", busy, 0);

        // Single run, done 10 cycles after start.
        clr();
        start_batch(1, 1'b0);
        check("busy_after_go", busy, 1);
        serve(10);
        wait_done(20);
        check("t1_n_res", n_res, 1);
        check("t1_cycles", qc(0), 11);
        check("t1_index", qi(0), 0);
        check("t1_timeout", qt(0), 0);
        check("t1_n_done", n_done, 1);
        check("t1_aborted", last_aborted, 0);
        check("t1_idle", busy, 0);

        // Three runs with latencies 5/1/7.
        clr();
        start_batch(3, 1'b0);
        serve(5);
        serve(1);
        serve(7);
        wait_done(30);
        check("t2_n_res", n_res, 3);
        check("t2_cycles0", qc(0), 6);
        check("t2_cycles1", qc(1), 2);
        check("t2_cycles2", qc(2), 8);
        check("t2_index0", qi(0), 0);
        check("t2_index1", qi(1), 1);
        check("t2_index2", qi(2), 2);
        check("t2_n_starts", n_starts, 3);
        check("t2_n_done", n_done, 1);
        check("t2_aborted", last_aborted, 0);
        tick(3);
        check("t2_cycles_held", res_cycles, 8);
        check("t2_index_held", res_index, 2);

        // Done ignored in IDLE; num_runs=0 runs once; done in the START cycle reads 1.
        clr();
        acc_done_port = 1'b1;
        tick(3);
        acc_done_port = 1'b0;
        check("t3_idle_done_busy", busy, 0);
        check("t3_idle_done_res", n_res, 0);
        start_batch(0, 1'b0);
        serve(0);
        wait_done(20);
        tick(20);
        check("t3_n_starts", n_starts, 1);
        check("t3_n_res", n_res, 1);
        check("t3_cycles", qc(0), 1);
        check("t3_n_done", n_done, 1);

        // Abort in WAIT of the second of four runs, go held high while busy.
        clr();
        start_batch(4, 1'b0);
        go = 1'b1; num_runs = 8'd1;
        serve(3);
        wait_start(seen);
        tick(3);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("t4_done_next_cycle", batch_done, 1);
        check("t4_aborted_flag", batch_aborted, 1);
        go = 1'b0;
        tick(5);
        check("t4_n_res", n_res, 1);
        check("t4_cycles", qc(0), 4);
        check("t4_n_starts", n_starts, 2);
        check("t4_n_done", n_done, 1);
        check("t4_aborted_held", batch_aborted, 1);
        check("t4_idle", busy, 0);

        // go and abort together in IDLE: go wins and clears the aborted flag.
        clr();
        start_batch(1, 1'b1);
        check("t5_go_wins_busy", busy, 1);
        check("t5_go_clears_aborted", batch_aborted, 0);
        serve(1);
        wait_done(20);
        check("t5_cycles", qc(0), 2);
        check("t5_aborted", last_aborted, 0);

        // Abort during REPORT: the report completes, then DONE.
        clr();
        start_batch(3, 1'b0);
        serve(2);
        begin
            int k = 0;
            while (!res_valid && k < 20) begin @(negedge clock); k++; end
        end
        check("t6_in_report", res_valid, 1);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("t6_done_after_report", batch_done, 1);
        check("t6_aborted", batch_aborted, 1);
        tick(5);
        check("t6_n_res", n_res, 1);
        check("t6_cycles", qc(0), 3);
        check("t6_n_starts", n_starts, 1);

        // Reset mid-WAIT, then a clean restart.
        clr();
        start_batch(2, 1'b0);
        wait_start(seen);
        tick(4);
        reset = 1'b1;
        #1;
        check_all_zero("midrun_reset");
        tick(2);
        reset = 1'b0;
        tick(10);
        check("t7_no_res", n_res, 0);
        check("t7_no_done", n_done, 0);
        check("t7_idle", busy, 0);
        clr();
        start_batch(1, 1'b0);
        serve(4);
        wait_done(20);
        check("t7_restart_index", qi(0), 0);
        check("t7_restart_cycles", qc(0), 5);

`ifdef HLS_RUN_SEQUENCER_TIMEOUT_EN
        // Watchdog: done never arrives.
        clr();
        start_batch(2, 1'b0);
        wait_done(200);
        tick(10);
        check("t8_n_res", n_res, 1);
        check("t8_timeout", qt(0), 1);
        check("t8_cycles", qc(0), 50);
        check("t8_aborted", last_aborted, 1);
        check("t8_n_starts", n_starts, 1);
`else
        check("t8_timeout_const", res_timeout, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hls_run_sequencer.md
HLS_RUN_SEQUENCER -- requirements
Module: hls_run_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of the cycle counter and of res_cycles.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 2: cycles acc_reset_n is held low before each run; legal range >=1.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 200000000: watchdog limit in cycles; must be < 2^CNT_W.
REQ-004 SHALL have ports:
- clock  in  1: single clock; all logic on its rising edge.
- reset  in  1: asynchronous, active-high.
- go  in  1: batch request, sampled only in IDLE.
- num_runs  in  8: runs per batch, sampled with go.
- abort  in  1: synchronous batch abort.
- acc_reset_n  out  1: accelerator reset, active-low.
- acc_start_port  out  1: one-cycle start pulse to the accelerator.
- acc_done_port  in  1: accelerator completion.
- busy  out  1: high in every state except IDLE.
- res_valid  out  1: one-cycle pulse per finished run.
- res_cycles  out  CNT_W: measured cycles of the run.
- res_timeout  out  1: run ended by watchdog.
- res_index  out  8: zero-based run number.
- batch_done  out  1: one-cycle pulse at batch end.
- batch_aborted  out  1: qualifies batch_done; high if abort or timeout ended the batch.

Function
REQ-005 SHALL implement the FSM IDLE -> RST -> ARM -> START -> WAIT -> REPORT -> (RST | DONE) -> IDLE.
REQ-006 IDLE: acc_reset_n=0. go=1 SHALL latch num_runs (0 treated as 1), clear run index, and enter RST.
REQ-007 RST: acc_reset_n=0 for exactly SETTLE_CYCLES cycles, then ARM.
REQ-008 ARM: acc_reset_n=1 for one cycle, no start, then START.
REQ-009 START: acc_start_port=1 for exactly one cycle; the counter SHALL load 1; then WAIT.
REQ-010 WAIT: the counter SHALL increment by 1 per cycle and saturate at 2^CNT_W-1.
REQ-011 acc_done_port=1 in START or WAIT SHALL end the run. res_cycles = counter value in that cycle (done in START gives 1). Next state is REPORT.
REQ-012 acc_done_port SHALL be ignored in IDLE, RST, ARM, REPORT and DONE.
REQ-013 REPORT: res_valid=1 for one cycle.
- res_cycles, res_timeout and res_index SHALL be valid then and held until the next REPORT.
- Then RST if runs remain and no timeout occurred, else DONE.
REQ-014 DONE: batch_done=1 for one cycle, then IDLE. batch_aborted SHALL hold until the next go is accepted.
REQ-015 abort=1 in any non-IDLE state SHALL go directly to DONE with batch_aborted=1. No res_valid is issued for the interrupted run, except when the state is REPORT: REPORT completes first, then the FSM enters DONE.
REQ-016 go while busy SHALL be ignored. go and abort together in IDLE: go wins, abort is ignored.
REQ-017 Start-to-start latency between consecutive runs SHALL be res_cycles + SETTLE_CYCLES + 3 cycles.

Reset
REQ-018 reset=1 SHALL asynchronously force the state to IDLE.
REQ-019 reset=1 SHALL set acc_reset_n, acc_start_port, res_valid, batch_done, batch_aborted, res_timeout and busy to 0, and res_cycles and res_index to 0.
REQ-020 Reset mid-run SHALL produce no res_valid or batch_done pulse.

Configuration
REQ-021 Macro HLS_RUN_SEQUENCER_TIMEOUT_EN SHALL compile in the watchdog.
REQ-022 With the macro defined: if the counter reaches TIMEOUT_CYCLES in WAIT with no done, the FSM SHALL enter REPORT with res_timeout=1 and res_cycles=TIMEOUT_CYCLES, then DONE with batch_aborted=1.
REQ-023 With the macro undefined: there is no watchdog, res_timeout is constant 0, and WAIT waits indefinitely.

Verification
REQ-024 go, num_runs=1, done 10 cycles after the start pulse -> one res_valid, res_cycles=11, res_index=0, batch_done=1, batch_aborted=0.
REQ-025 num_runs=3, done latencies 5/1/7 -> res_cycles 6/2/8, res_index 0/1/2, acc_reset_n low for 2 cycles before each start, one batch_done.
REQ-026 num_runs=0 -> exactly one run executed, then batch_done.
REQ-027 Macro defined, TIMEOUT_CYCLES=50, done never asserted -> res_timeout=1, res_cycles=50, batch_aborted=1, no further start.
REQ-028 abort in WAIT of run 1 of 4 -> no res_valid for run 1, batch_done with batch_aborted=1 next cycle; go while busy ignored throughout.
REQ-029 reset asserted in WAIT -> all outputs 0 immediately, FSM in IDLE, no pulses; a new go then restarts with res_index=0.
